// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: one outstanding memory read per PC, buffers the reply for decode.
// Optional watchdog on WAIT/FLUSH enabled by defining FETCH_TIMEOUT_EN.
`timescale 1ns/1ps
module fetch_seq #(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            redirect,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [31:0]     resp_data,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_comp,
    output logic            fetch_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FLUSH = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       inst_reg, inst_next;
    logic [XLEN-1:0]   inst_pc_reg, inst_pc_next;
    logic              timeout_hit;
    logic              timeout_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            inst_reg    <= 32'd0;
            inst_pc_reg <= '0;
        end else begin
            state_reg   <= state_next;
            inst_reg    <= inst_next;
            inst_pc_reg <= inst_pc_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        inst_next    = inst_reg;
        inst_pc_next = inst_pc_reg;
        timeout_fire = 1'b0;
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                // A request accepted in a redirect cycle targets the old path; its reply must be drained.
                if (req_ready) begin
                    if (redirect) begin
                        state_next = FLUSH;
                    end else begin
                        inst_pc_next = pc;
                        state_next   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (resp_valid) begin
                    if (redirect) begin
                        state_next = REQ;
                    end else begin
                        inst_next  = resp_data;
                        state_next = HOLD;
                    end
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    state_next   = REQ;
                end else if (redirect) begin
                    state_next = FLUSH;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_next = REQ;
                end
            end
            FLUSH: begin
                if (resp_valid) begin
                    state_next = REQ;
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    state_next   = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg;
    logic             in_wait_flush;

    assign in_wait_flush = (state_reg == WAIT) || (state_reg == FLUSH);
    assign timeout_hit   = in_wait_flush && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every entry into WAIT or FLUSH, including WAIT -> FLUSH.
    always_comb begin
        cnt_next = cnt_reg;
        if ((state_next != state_reg) && ((state_next == WAIT) || (state_next == FLUSH))) begin
            cnt_next = '0;
        end else if (in_wait_flush) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (timeout_fire) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign fetch_err = err_reg;
`else
    logic unused_timeout_cfg;

    // Without the watchdog the limit has no effect.
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign fetch_err          = 1'b0;
`endif

    assign req_valid  = (state_reg == REQ);
    assign req_addr   = {pc[XLEN-1:1], 1'b0};
    assign inst_valid = (state_reg == HOLD);
    assign inst       = inst_reg;
    assign inst_pc    = inst_pc_reg;
    assign inst_comp  = inst_valid & (inst_reg[1:0] != 2'b11);

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Sequences instruction fetch for the front end: issues one memory read per PC, buffers the returned instruction, and presents it to the PC controller as inst_valid/inst_comp.
- Sits between the PC register and the instruction memory port.
- Handles redirects (trap or branch/jump) by dropping in-flight fetches so that no instruction fetched before a redirect is ever presented.
- At most one outstanding request.

Parameters:
- XLEN, 64, width of pc and req_addr
- TIMEOUT_CYCLES, 255, WAIT/FLUSH cycles before fetch_err (used only with FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset; one clock, reset sampled on the rising edge of clk
- pc  in  XLEN  current fetch PC from the PC controller
- stall  in  1  decode back-pressure; the instruction is not consumed while high
- redirect  in  1  trap or branch/jump redirect this cycle; pc holds the target from the next cycle
- req_valid  out  1  fetch request valid
- req_ready  in  1  memory accepts request
- req_addr  out  XLEN  fetch address (halfword aligned)
- resp_valid  in  1  response data valid; one response per accepted request, never earlier than the cycle after acceptance
- resp_data  in  32  fetched instruction bits
- inst_valid  out  1  buffered instruction valid
- inst  out  32  buffered instruction
- inst_pc  out  XLEN  PC of the buffered instruction
- inst_comp  out  1  buffered instruction is compressed: inst[1:0] != 2'b11
- fetch_err  out  1  timeout flag (FETCH_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- States: IDLE, REQ, WAIT, HOLD, FLUSH.
- Reset (rst=1 at clk edge):
  - state=IDLE; req_valid=0, inst_valid=0, inst=0, inst_pc=0, fetch_err=0.
  - Reset mid-transaction abandons the transaction. The memory side is reset alongside, so no stale response is expected.
- IDLE: unconditionally -> REQ the next cycle.
- REQ:
  - req_valid=1, req_addr=pc (combinational, so the address follows pc).
  - req_valid && req_ready && !redirect: latch inst_pc<=pc, -> WAIT.
  - req_valid && req_ready && redirect: the accepted request is stale, -> FLUSH.
  - No handshake: stay in REQ, with or without redirect.
- WAIT:
  - req_valid=0.
  - resp_valid && !redirect: inst<=resp_data, -> HOLD.
  - resp_valid && redirect: discard the response, -> REQ.
  - !resp_valid && redirect: -> FLUSH.
- HOLD:
  - inst_valid=1, driven directly from state (registered). inst and inst_pc are stable.
  - redirect (priority over stall): -> REQ; the instruction is dropped.
  - !stall: the instruction is consumed this cycle (the PC controller advances pc by 2 or 4 on this edge), -> REQ.
  - stall: remain in HOLD.
- FLUSH:
  - req_valid=0, inst_valid=0.
  - resp_valid: discard, -> REQ.
  - A further redirect has no additional effect.
- Throughput: minimum 3 cycles per instruction (REQ, WAIT, HOLD) with zero-latency memory acceptance and a 1-cycle response.
- inst_comp = inst_valid & (inst[1:0] != 2'b11); 0 outside HOLD.
- The PC controller holds pc whenever inst_valid=0, so in REQ pc equals the address to fetch.
- resp_valid in REQ or IDLE is a protocol violation; it is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter clears on entry to WAIT or FLUSH and increments each cycle spent there.
  - Reaching TIMEOUT_CYCLES sets fetch_err=1 (sticky until rst) and forces -> REQ, abandoning the fetch.
  - A late response after timeout is treated as a protocol violation and ignored.
- When undefined: no counter; fetch_err tied 0; WAIT/FLUSH wait indefinitely.

Test Plan:
- Reset, then pc=0x1000, req_ready=1, resp 1 cycle later with data 0x00000013, stall=0 -> req_addr=0x1000 in REQ; inst_valid=1 for exactly 1 cycle; inst=0x13; inst_comp=0; inst_pc=0x1000; next req_addr=0x1004.
- Compressed instruction: resp_data=0x00004501 at pc=0x2000 -> inst_comp=1; next request at 0x2002.
- Stall: hold stall=1 for 5 cycles in HOLD -> inst_valid stays 1 and inst stable, no new req_valid; release -> REQ the following cycle.
- Redirect in WAIT (pc 0x3000 -> target 0x8000) -> FLUSH; the response for 0x3000 (data 0xDEADBEEF) is never presented; next req_addr=0x8000; only the instruction from 0x8000 is presented.
- Redirect coincident with req handshake at 0x4000, and separately with resp_valid in WAIT -> both discarded; no inst_valid for 0x4000; next request at the target.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, resp_valid never asserted -> fetch_err=1 after 16 WAIT cycles; state returns to REQ; fetch_err remains 1 until rst.
